// File: rtl/usb_clk_sequencer.sv
// usb_clk_sequencer: reset stretcher, soft-reset sequencer, heartbeat and
// trigger-stretch LEDs running on the buffered global USB clock.
// Optional feature macro: USB_CLK_HEARTBEAT_EN (builds the heartbeat counter;
// when undefined, led_hb_o simply mirrors ready_o).
module usb_clk_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned HB_BITS         = 23,
    parameter int unsigned STRETCH_BITS    = 22
) (
    input  logic usb_clk,
    input  logic reset_i,
    input  logic soft_rst_i,
    input  logic trig_i,
    output logic rst_out_o,
    output logic ready_o,
    output logic led_hb_o,
    output logic led_trig_o
);

    localparam int unsigned HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reject parameter values outside the supported range at elaboration
    if (RST_HOLD_CYCLES < 2 || RST_HOLD_CYCLES > 65535 || HB_BITS < 1 || STRETCH_BITS < 1)
    begin : g_param_check
        $error("usb_clk_sequencer: illegal parameter value");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [HOLD_W-1:0]       hold_nxt;
    logic [STRETCH_BITS-1:0] str_cnt;
    logic                    trig_q;
    logic                    trig_rise;

    assign trig_rise = trig_i & ~trig_q;

    // State and hold-counter register
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state    <= HOLD;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state and hold-counter decode; soft reset restarts the hold period
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            HOLD: begin
                if (soft_rst_i) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (soft_rst_i) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = HOLD;
                hold_nxt  = '0;
            end
        endcase
    end

    // Trigger history and stretch counter; soft reset in RUN wins over an edge
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            trig_q  <= 1'b0;
            str_cnt <= '0;
        end else begin
            trig_q <= trig_i;
            if (state != RUN || soft_rst_i) begin
                str_cnt <= '0;
            end else if (trig_rise) begin
                str_cnt <= '1;
            end else if (str_cnt != '0) begin
                str_cnt <= str_cnt - STRETCH_BITS'(1);
            end
        end
    end

`ifdef USB_CLK_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_cnt;

    // Heartbeat counter: counts only while running, held at zero otherwise
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            hb_cnt <= '0;
        end else if (state == RUN && !soft_rst_i) begin
            hb_cnt <= hb_cnt + HB_BITS'(1);
        end else begin
            hb_cnt <= '0;
        end
    end
`endif

    // Output decode from registers only
    always_comb begin
        rst_out_o  = 1'b1;
        ready_o    = 1'b0;
        led_trig_o = (str_cnt != '0);
        if (state == RUN) begin
            rst_out_o = 1'b0;
            ready_o   = 1'b1;
        end
`ifdef USB_CLK_HEARTBEAT_EN
        led_hb_o = hb_cnt[HB_BITS-1];
`else
        led_hb_o = (state == RUN);
`endif
    end

endmodule

// File: tb/tb_usb_clk_sequencer.sv
// Scoreboard bench for usb_clk_sequencer with RST_HOLD_CYCLES=4, HB_BITS=3,
// STRETCH_BITS=2. Expected outputs per edge are hand-computed, packed as
// {rst_out, ready, led_hb, led_trig}; led_hb values assume the heartbeat
// build and are replaced by ready when USB_CLK_HEARTBEAT_EN is undefined.
module tb_usb_clk_sequencer;

    typedef struct packed {
        logic       r;
        logic       s;
        logic       t;
        logic [3:0] e;
    } vec_t;

    logic usb_clk;
    logic reset_i;
    logic soft_rst_i;
    logic trig_i;
    logic rst_out_o;
    logic ready_o;
    logic led_hb_o;
    logic led_trig_o;

    vec_t  vq[$];
    string nq[$];
    vec_t  exp_q[$];
    string exp_nq[$];

    int total;
    int bad;

    usb_clk_sequencer #(
        .RST_HOLD_CYCLES(4),
        .HB_BITS        (3),
        .STRETCH_BITS   (2)
    ) dut (
        .usb_clk   (usb_clk),
        .reset_i   (reset_i),
        .soft_rst_i(soft_rst_i),
        .trig_i    (trig_i),
        .rst_out_o (rst_out_o),
        .ready_o   (ready_o),
        .led_hb_o  (led_hb_o),
        .led_trig_o(led_trig_o)
    );

    initial begin
        usb_clk = 1'b0;
        forever #5 usb_clk = ~usb_clk;
    end

    function automatic void add(input logic r, input logic s, input logic t,
                                input logic [3:0] e, input string n);
        vec_t v;
        v.r = r;
        v.s = s;
        v.t = t;
        v.e = e;
        vq.push_back(v);
        nq.push_back(n);
    endfunction

    // Monitor: pop one expectation per edge and compare just after the edge
    initial begin
        vec_t       v;
        string      n;
        logic [3:0] got;
        logic [3:0] want;
        forever begin
            @(posedge usb_clk);
            #1;
            if (exp_q.size() > 0) begin
                v    = exp_q.pop_front();
                n    = exp_nq.pop_front();
                want = v.e;
`ifndef USB_CLK_HEARTBEAT_EN
                want[1] = want[2];
`endif
                got   = {rst_out_o, ready_o, led_hb_o, led_trig_o};
                total = total + 1;
                if (got !== want) begin
                    bad = bad + 1;
                    $display("FAIL %s: got rst/rdy/hb/trig=%b want=%b at %0t", n, got, want, $time);
                end
            end
        end
    end

    // Stimulus: build the directed table, then drive one vector per cycle
    initial begin
        vec_t v;
        total      = 0;
        bad        = 0;
        reset_i    = 1'b1;
        soft_rst_i = 1'b0;
        trig_i     = 1'b0;

        for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b1000, "reset");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b1000, "release_hold");
        add(0, 0, 0, 4'b0100, "run_entry");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0100, "hb_low");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 4'b0110, "hb_high");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 4'b0100, "hb_low2");
        add(0, 0, 0, 4'b0110, "hb_high2");
        add(0, 0, 1, 4'b0111, "trig_load");
        add(0, 0, 0, 4'b0111, "trig_2");
        add(0, 0, 0, 4'b0111, "trig_3");
        add(0, 0, 0, 4'b0100, "trig_off");
        add(0, 0, 0, 4'b0100, "gap");
        add(0, 0, 1, 4'b0101, "retrig_1");
        add(0, 0, 0, 4'b0101, "retrig_2");
        add(0, 0, 1, 4'b0111, "retrig_3");
        add(0, 0, 0, 4'b0111, "retrig_4");
        add(0, 0, 0, 4'b0111, "retrig_5");
        add(0, 0, 0, 4'b0110, "retrig_off");
        add(0, 0, 1, 4'b0101, "held_1");
        add(0, 0, 1, 4'b0101, "held_2");
        add(0, 0, 1, 4'b0101, "held_3");
        add(0, 0, 1, 4'b0100, "held_off");
        for (int i = 0; i < 4; i++) add(0, 0, 1, 4'b0110, "held_hb");
        add(0, 0, 1, 4'b0100, "held_hb_wrap");
        add(0, 0, 1, 4'b0100, "held_last");
        add(0, 0, 0, 4'b0100, "held_release");
        add(0, 1, 1, 4'b1000, "soft_run_vs_trig");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b1000, "soft_run_hold");
        add(0, 0, 0, 4'b0100, "soft_run_exit");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0100, "hb_restart_low");
        add(0, 0, 0, 4'b0110, "hb_restart_high");
        add(0, 0, 1, 4'b0111, "pre_reset");
        add(1, 0, 0, 4'b1000, "mid_reset");
        add(0, 0, 0, 4'b1000, "soft_hold_c1");
        add(0, 0, 0, 4'b1000, "soft_hold_c2");
        add(0, 1, 0, 4'b1000, "soft_hold_req");
        add(0, 1, 0, 4'b1000, "soft_hold_req2");
        add(0, 0, 0, 4'b1000, "soft_hold_r1");
        add(0, 0, 1, 4'b1000, "soft_hold_r2_trig");
        add(0, 0, 1, 4'b1000, "soft_hold_r3_trig");
        add(0, 0, 1, 4'b0100, "run_trig_high");
        add(0, 0, 1, 4'b0100, "no_edge_at_entry");
        add(0, 0, 0, 4'b0100, "final");

        while (vq.size() > 0) begin
            @(negedge usb_clk);
            v          = vq.pop_front();
            reset_i    = v.r;
            soft_rst_i = v.s;
            trig_i     = v.t;
            exp_q.push_back(v);
            exp_nq.push_back(nq.pop_front());
        end
        @(negedge usb_clk);
        soft_rst_i = 1'b0;
        trig_i     = 1'b0;
        @(negedge usb_clk);
        @(negedge usb_clk);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
